nco_tune_ctrl: RTL

Frequency-tuning controller for the NCO core. Accepts phase-increment change requests over a valid/ready port, applies them immediately or as a linear frequency ramp, and drives the NCO's `clken` and `phi_inc_i` inputs. It withholds a `settled` indication until the NCO pipeline has flushed samples generated at the final increment. It sits between the control/AFC logic and the NCO instance.

---
 rtl/nco_ctrl_pkg.sv | 20 ++
 rtl/nco_ramp_step.sv | 36 +++
 rtl/nco_tune_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nco_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | nco_ctrl_pkg : shared types and defaults for the NCO tuning controller     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package nco_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int c_APR_DEFAULT = 22;
  localparam int c_LAT_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/nco_ramp_step.sv
// +----------------------------------------------------------------------------+
// | nco_ramp_step : next ramp increment from (current, target, step)           |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module nco_ramp_step
  import nco_ctrl_pkg::*;
#(
  parameter int APR = c_APR_DEFAULT
) (
  input  logic [APR-1:0] cur,
  input  logic [APR-1:0] tgt,
  input  logic [APR-1:0] step,
  output logic [APR-1:0] next_inc,
  output logic           last
);

  logic         w_up;
  logic [APR:0] w_diff;

  assign w_up   = (tgt > cur);
  // One extra bit keeps the magnitude exact across the full unsigned range.
  assign w_diff = w_up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
  assign last   = (w_diff <= {1'b0, step});

  always_comb begin
    next_inc = tgt;
    if (!last) begin
      next_inc = w_up ? (cur + step) : (cur - step);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nco_tune_ctrl.sv
// +----------------------------------------------------------------------------+
// | nco_tune_ctrl : phase-increment tuning (jump / linear ramp) with settle    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module nco_tune_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int             APR      = c_APR_DEFAULT,
  parameter int             LAT      = c_LAT_DEFAULT,
  parameter int             RAMP_DIV = 16,
  parameter logic [APR-1:0] INIT_INC = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           hold,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [APR-1:0] cfg_inc,
  input  logic [APR-1:0] cfg_step,
  input  logic           nco_out_valid,
  output logic           nco_clken,
  output logic [APR-1:0] nco_phi_inc,
  output logic           busy,
  output logic           settled
);

  localparam int c_DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int c_CNT_W = $clog2(LAT + 2);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RAMP_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  state_t             r_state;
  logic [APR-1:0]     r_phi_inc;
  logic [APR-1:0]     r_target;
  logic [APR-1:0]     r_step;
  logic [c_DIV_W-1:0] r_div;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_cfg_ready;
  logic               r_busy;
  logic               r_settled;

  logic               w_tick;
  logic               w_accept;
  logic               w_immediate;
  logic [APR-1:0]     w_next_inc;
  logic               w_last;

  assign w_tick      = en & ~hold;
  assign w_accept    = cfg_valid & r_cfg_ready;
  assign w_immediate = (cfg_step == '0) || (cfg_inc == r_phi_inc);

  nco_ramp_step #(
    .APR (APR)
  ) u_ramp_step (
    .cur      (r_phi_inc),
    .tgt      (r_target),
    .step     (r_step),
    .next_inc (w_next_inc),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_phi_inc   <= INIT_INC;
      r_target    <= '0;
      r_step      <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_settled   <= 1'b0;
    end else begin
      r_settled <= (r_state == IDLE) & nco_out_valid;
      case (r_state)
        IDLE, SETTLE: begin
          if (w_accept) begin
            r_target <= cfg_inc;
            r_step   <= cfg_step;
            r_busy   <= 1'b1;
            if (w_immediate) begin
              r_phi_inc   <= cfg_inc;
              r_cnt       <= c_LAT_LOAD;
              r_state     <= SETTLE;
              r_cfg_ready <= 1'b1;
            end else begin
              r_div       <= '0;
              r_state     <= RAMP;
              r_cfg_ready <= 1'b0;
            end
          end else if ((r_state == SETTLE) && w_tick) begin
            // The tick that drains the last pipeline slot also retires the settle.
            if ((r_cnt <= c_CNT_ONE) && nco_out_valid) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
        end
        RAMP: begin
          if (w_tick) begin
            if (r_div == c_DIV_LAST) begin
              r_div     <= '0;
              r_phi_inc <= w_next_inc;
              if (w_last) begin
                r_cnt       <= c_LAT_LOAD;
                r_state     <= SETTLE;
                r_cfg_ready <= 1'b1;
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign nco_clken   = w_tick;
  assign cfg_ready   = r_cfg_ready;
  assign nco_phi_inc = r_phi_inc;
  assign busy        = r_busy;
  assign settled     = r_settled;

endmodule

`default_nettype wire
